axil_master_bridge: RTL and testbench

- Single-outstanding AXI-Lite master (initiator) that turns a simple valid/ready command/response interface into AXI-Lite read or write transactions.
- Sits between the core's load/store unit and the AXI-Lite interconnect that fans out to peripheral slaves (GPIO, UART, timers).
- Provides independent AW/W handshaking, response buffering, and local rejection of misaligned accesses.

---
 rtl/axil_pkg.sv | 28 ++
 rtl/axil_master_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_axil_master_bridge.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, default protection and the
// master bridge state encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] ST_WR_RESP      = 3'd2;
    localparam logic [2:0] ST_RD_ADDR      = 3'd3;
    localparam logic [2:0] ST_RD_DATA      = 3'd4;
    localparam logic [2:0] ST_RESP         = 3'd5;

    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        WR_ADDR_DATA = ST_WR_ADDR_DATA,
        WR_RESP      = ST_WR_RESP,
        RD_ADDR      = ST_RD_ADDR,
        RD_DATA      = ST_RD_DATA,
        RESP         = ST_RESP
    } bridge_state_e;

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI-Lite master: converts a valid/ready command into one
// AXI-Lite read or write and returns a buffered response.
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_misalign,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    bridge_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0] rsp_resp_q, rsp_resp_d;
    logic rsp_mis_q, rsp_mis_d;

    logic aw_hs, w_hs;

    assign aw_hs = awvalid_q & m_axil_awready;
    assign w_hs  = wvalid_q & m_axil_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_mis_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_mis_q   <= rsp_mis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_mis_d   = rsp_mis_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_OKAY;
                    rsp_mis_d   = 1'b0;
                    // Misaligned commands never reach the bus.
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_d    = RESP;
                        rsp_mis_d  = 1'b1;
                        rsp_resp_d = RESP_SLVERR;
                    end else if (cmd_we) begin
                        state_d   = WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Either channel may finish first; move on once both have.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (bready_q & m_axil_bvalid) begin
                    rsp_resp_d = m_axil_bresp;
                    bready_d   = 1'b0;
                    state_d    = RESP;
                end
            end
            RD_ADDR: begin
                if (arvalid_q & m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready_q & m_axil_rvalid) begin
                    rsp_rdata_d = m_axil_rdata;
                    rsp_resp_d  = m_axil_rresp;
                    rready_d    = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready      = (state_q == IDLE) & ~rst;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_misalign   = rsp_mis_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = PROT_DEFAULT;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = PROT_DEFAULT;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: register-ready AXI-Lite responder with
// programmable stalls, and a word-array reference of the expected responses.
module tb_axil_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_misalign;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axil_master_bridge dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_misalign(rsp_misalign),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    int checks = 0;
    int failures = 0;

    // Responder knobs
    int       aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic     b_block = 1'b0;

    logic [31:0] slv_mem [16];
    logic [31:0] model_mem [16];
    int       aw_cnt, w_cnt, ar_cnt;
    logic     aw_got, w_got;
    logic [3:0]  aw_idx, b_idx;
    logic [31:0] w_data_l, b_data;
    logic [3:0]  w_strb_l, b_strb;

    wire s_aw_hs = awvalid && awready;
    wire s_w_hs  = wvalid && wready;

    assign b_idx  = s_aw_hs ? awaddr[5:2] : aw_idx;
    assign b_data = s_w_hs ? wdata : w_data_l;
    assign b_strb = s_w_hs ? wstrb : w_strb_l;

    always @(posedge clk) begin
        if (rst) begin
            awready <= 0; wready <= 0; arready <= 0; bvalid <= 0; rvalid <= 0;
            bresp <= 0; rresp <= 0; rdata <= 0; aw_got <= 0; w_got <= 0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_idx <= 0; w_data_l <= 0; w_strb_l <= 0;
            for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
        end else begin
            awready <= 0; wready <= 0; arready <= 0;
            if (awvalid && !awready && !aw_got) begin
                if (aw_cnt >= aw_dly) begin awready <= 1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && !wready && !w_got) begin
                if (w_cnt >= w_dly) begin wready <= 1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if (arvalid && !arready && !rvalid) begin
                if (ar_cnt >= ar_dly) begin arready <= 1; ar_cnt <= 0; end
                else ar_cnt <= ar_cnt + 1;
            end
            if (bvalid && bready) bvalid <= 0;
            if (rvalid && rready) rvalid <= 0;
            if (arvalid && arready) begin
                rvalid <= 1; rdata <= slv_mem[araddr[5:2]]; rresp <= rresp_cfg;
            end
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !b_block && !bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (b_strb[b]) slv_mem[b_idx][8*b +: 8] <= b_data[8*b +: 8];
                bvalid <= 1; bresp <= bresp_cfg; aw_got <= 0; w_got <= 0;
            end else begin
                if (s_aw_hs) begin aw_got <= 1; aw_idx <= awaddr[5:2]; end
                if (s_w_hs) begin w_got <= 1; w_data_l <= wdata; w_strb_l <= wstrb; end
            end
        end
    end

    // Bus activity bookkeeping
    int cyc = 0, n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_vcyc = 0, n_wfirst = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0;
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (s_aw_hs) begin n_aw++; aw_hs_cyc = cyc; end
            if (s_w_hs) begin n_w++; w_hs_cyc = cyc; end
            if (bvalid && bready) n_b++;
            if (arvalid && arready) n_ar++;
            if (rvalid && rready) n_r++;
            if (awvalid || wvalid || arvalid) n_vcyc++;
            if (awvalid && !wvalid) n_wfirst++;
        end
    end

    // A valid that has not handshaken must still be high one cycle later.
    logic aw_pend = 0, w_pend = 0, ar_pend = 0, prev_rst = 1;
    always @(negedge clk) begin
        if (!rst && !prev_rst) begin
            if (aw_pend) begin
                checks++;
                assert (awvalid === 1'b1) else begin failures++; $error("FAIL awvalid_held got %b want 1", awvalid); end
            end
            if (w_pend) begin
                checks++;
                assert (wvalid === 1'b1) else begin failures++; $error("FAIL wvalid_held got %b want 1", wvalid); end
            end
            if (ar_pend) begin
                checks++;
                assert (arvalid === 1'b1) else begin failures++; $error("FAIL arvalid_held got %b want 1", arvalid); end
            end
        end
        aw_pend  = awvalid && !awready;
        w_pend   = wvalid && !wready;
        ar_pend  = arvalid && !arready;
        prev_rst = rst;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold,
                          output logic [31:0] rd, output logic [1:0] rs,
                          output logic mis, output int lat);
        int n;
        @(negedge clk);
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        chk("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
        rd = rsp_rdata; rs = rsp_resp; mis = rsp_misalign;
        for (int i = 0; i < hold; i++) begin
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_resp", {30'd0, rsp_resp}, {30'd0, rs});
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Reference: word-addressed memory, misaligned -> SLVERR with no bus access.
    task automatic run(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input int hold,
                       output int lat);
        logic [31:0] er, rd, mask;
        logic [1:0]  es, rs;
        logic        em, mis;
        int          v0;
        if (a[1:0] != 2'b00) begin
            er = 0; es = 2'b10; em = 1;
        end else if (we) begin
            mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            model_mem[a[5:2]] = (model_mem[a[5:2]] & ~mask) | (d & mask);
            er = 0; es = bresp_cfg; em = 0;
        end else begin
            er = model_mem[a[5:2]]; es = rresp_cfg; em = 0;
        end
        v0 = n_vcyc;
        do_cmd(we, a, d, s, hold, rd, rs, mis, lat);
        chk({tag, "_rdata"}, rd, er);
        chk({tag, "_resp"}, {30'd0, rs}, {30'd0, es});
        chk({tag, "_misalign"}, {31'd0, mis}, {31'd0, em});
        if (em) chk({tag, "_no_bus"}, n_vcyc - v0, 32'd0);
    endtask

    initial begin
        int lat, a0, w0, b0, wf0, n;
        logic [31:0] ra;
        rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 0;
        @(negedge clk);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
        chk("idle_misalign", {31'd0, rsp_misalign}, 32'd0);
        chk("idle_latched", awaddr | wdata | {28'd0, wstrb} | {26'd0, awprot, arprot}, 32'd0);

        // Zero-wait write: AW and W complete together
        a0 = n_aw; w0 = n_w; b0 = n_b;
        run("wr_basic", 1, 32'h08, 32'hA5A5_00FF, 4'hF, 0, lat);
        chk("wr_basic_lat", lat, 32'd4);
        chk("wr_basic_aw_w_same", aw_hs_cyc - w_hs_cyc, 32'd0);
        chk("wr_basic_hs", {(n_aw - a0) == 1, (n_w - w0) == 1, (n_b - b0) == 1}, 32'd7);

        // W accepted three cycles before AW
        aw_dly = 3; w_dly = 0; b0 = n_b; wf0 = n_wfirst;
        run("wr_wfirst", 1, 32'h0C, 32'hDEAD_BEEF, 4'hF, 0, lat);
        chk("wr_wfirst_gap", aw_hs_cyc - w_hs_cyc, 32'd3);
        chk("wr_wfirst_only_aw", n_wfirst - wf0, 32'd3);
        chk("wr_wfirst_one_b", n_b - b0, 32'd1);
        aw_dly = 0;

        // Read back with a stalled consumer
        run("wr_seed", 1, 32'h00, 32'h1234_5678, 4'hF, 0, lat);
        run("rd_hold", 0, 32'h00, 32'h0, 4'h0, 5, lat);
        chk("rd_hold_lat", lat, 32'd4);

        // Error response passes through
        rresp_cfg = 2'b10;
        run("rd_slverr", 0, 32'h00, 32'h0, 4'h0, 0, lat);
        rresp_cfg = 2'b00;

        // Misaligned write is rejected locally
        run("wr_misal", 1, 32'h06, 32'hFFFF_FFFF, 4'hF, 0, lat);
        chk("wr_misal_lat", lat, 32'd1);

        // Reset while waiting for B
        b_block = 1;
        @(negedge clk);
        cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h10; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!bready && n < 50) begin @(negedge clk); n++; end
        chk("rstmid_bready_up", {31'd0, bready}, 32'd1);
        rst = 1;
        @(negedge clk);
        chk("rstmid_bready", {31'd0, bready}, 32'd0);
        chk("rstmid_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
        chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst = 0; b_block = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = 0;
        @(negedge clk);
        chk("rstmid_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        run("rstmid_read", 0, 32'h10, 32'h0, 4'h0, 0, lat);
        chk("rstmid_read_lat", lat, 32'd4);

        // Randomised traffic
        for (int k = 0; k < 30; k++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom);
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            run("rand", 1'($urandom), ra, $urandom, 4'($urandom), $urandom_range(0, 3), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
